// File: rtl/axil_rd_arbiter_pkg.sv
// Shared types and helpers for the AXI4-lite read arbiter slice.
package axil_rd_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Index width for a port count; a single port still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_rd_arbiter_rr.sv
// Round-robin request picker: first requester at or after the pointer wins;
// an acknowledge moves the pointer to one past the acknowledged port.
module axil_rd_arbiter_rr
    import axil_rd_arbiter_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int IDX_W = idx_width(PORTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] req,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_index,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_index
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Scan from the farthest candidate down so the nearest requester is written last.
    always_comb begin : p_pick
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_index = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= PORTS) begin
                idx = idx - PORTS;
            end
            if (req[IDX_W'(idx)]) begin
                grant_valid = 1'b1;
                grant_index = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (ack) begin
            ptr_d = (ack_index == IDX_W'(PORTS - 1)) ? '0 : ack_index + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axil_rd_arbiter.sv
// Shares one AXI4-lite read master between S_COUNT requesters, one read in flight,
// round-robin grant held from the IDLE decision until the response is taken.
module axil_rd_arbiter
    import axil_rd_arbiter_pkg::*;
#(
    parameter int S_COUNT    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [S_COUNT*3-1:0]          s_axil_arprot,
    input  logic [S_COUNT-1:0]            s_axil_arvalid,
    output logic [S_COUNT-1:0]            s_axil_arready,
    output logic [S_COUNT*DATA_WIDTH-1:0] s_axil_rdata,
    output logic [S_COUNT*2-1:0]          s_axil_rresp,
    output logic [S_COUNT-1:0]            s_axil_rvalid,
    input  logic [S_COUNT-1:0]            s_axil_rready,
    output logic [ADDR_WIDTH-1:0]         m_axil_araddr,
    output logic [2:0]                    m_axil_arprot,
    output logic                          m_axil_arvalid,
    input  logic                          m_axil_arready,
    input  logic [DATA_WIDTH-1:0]         m_axil_rdata,
    input  logic [1:0]                    m_axil_rresp,
    input  logic                          m_axil_rvalid,
    output logic                          m_axil_rready
);

    localparam int                   IDX_W    = idx_width(S_COUNT);
    localparam logic [S_COUNT-1:0]   PORT_ONE = S_COUNT'(1);

    // Write strobes have no role on the read path; the width exists for port-set symmetry.
    if (STRB_WIDTH * 8 != DATA_WIDTH) begin : g_strb_width_mismatch
    end

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [S_COUNT-1:0]      arready_q, arready_d;
    logic [S_COUNT-1:0]      rvalid_q, rvalid_d;
    logic                    m_arvalid_q, m_arvalid_d;
    logic                    m_rready_q, m_rready_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [2:0]              arprot_q, arprot_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;

    logic                    arb_valid;
    logic [IDX_W-1:0]        arb_index;
    logic                    arb_ack;

    logic [ADDR_WIDTH-1:0]   araddr_arr [S_COUNT];
    logic [2:0]              arprot_arr [S_COUNT];

    genvar gi;
    for (gi = 0; gi < S_COUNT; gi++) begin : g_port
        assign araddr_arr[gi] = s_axil_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign arprot_arr[gi] = s_axil_arprot[gi*3 +: 3];
        assign s_axil_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
        assign s_axil_rresp[gi*2 +: 2] = rresp_q;
    end

    axil_rd_arbiter_rr #(
        .PORTS (S_COUNT),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         (s_axil_arvalid),
        .ack         (arb_ack),
        .ack_index   (grant_q),
        .grant_valid (arb_valid),
        .grant_index (arb_index)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        arready_d   = '0;
        rvalid_d    = rvalid_q;
        m_arvalid_d = m_arvalid_q;
        m_rready_d  = m_rready_q;
        araddr_d    = araddr_q;
        arprot_d    = arprot_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        arb_ack     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d   = arb_index;
                    arready_d = PORT_ONE << arb_index;
                    state_d   = ST_ACCEPT;
                end
            end
            // arready is a one-cycle pulse; a requester that withdrew gets re-arbitrated.
            ST_ACCEPT: begin
                if (s_axil_arvalid[grant_q]) begin
                    araddr_d    = araddr_arr[grant_q];
                    arprot_d    = arprot_arr[grant_q];
                    m_arvalid_d = 1'b1;
                    state_d     = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (m_axil_arready) begin
                    m_arvalid_d = 1'b0;
                    m_rready_d  = 1'b1;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (m_axil_rvalid) begin
                    rdata_d    = m_axil_rdata;
                    rresp_d    = m_axil_rresp;
                    m_rready_d = 1'b0;
                    rvalid_d   = PORT_ONE << grant_q;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (s_axil_rready[grant_q]) begin
                    rvalid_d = '0;
                    arb_ack  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            arready_q   <= '0;
            rvalid_q    <= '0;
            m_arvalid_q <= 1'b0;
            m_rready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            m_arvalid_q <= m_arvalid_d;
            m_rready_q  <= m_rready_d;
        end
    end

    // Payload registers carry no reset; they are only observed alongside a valid.
    always_ff @(posedge clk) begin
        araddr_q <= araddr_d;
        arprot_q <= arprot_d;
        rdata_q  <= rdata_d;
        rresp_q  <= rresp_d;
    end

    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = arprot_q;
    assign m_axil_arvalid = m_arvalid_q;
    assign m_axil_rready  = m_rready_q;

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Scoreboard bench for axil_rd_arbiter: requesters and a slave model driven per cycle,
// expected reads queued at issue time and compared when the requester takes the response.
module tb_axil_rd_arbiter;

    localparam int S  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [S*AW-1:0] s_araddr;
    logic [S*3-1:0]  s_arprot;
    logic [S-1:0]    s_arvalid;
    logic [S-1:0]    s_arready;
    logic [S*DW-1:0] s_rdata;
    logic [S*2-1:0]  s_rresp;
    logic [S-1:0]    s_rvalid;
    logic [S-1:0]    s_rready;
    logic [AW-1:0]   m_araddr;
    logic [2:0]      m_arprot;
    logic            m_arvalid;
    logic            m_arready;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rvalid;
    logic            m_rready;

    always #5 clk = ~clk;

    axil_rd_arbiter #(
        .S_COUNT    (S),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_araddr  (s_araddr),
        .s_axil_arprot  (s_arprot),
        .s_axil_arvalid (s_arvalid),
        .s_axil_arready (s_arready),
        .s_axil_rdata   (s_rdata),
        .s_axil_rresp   (s_rresp),
        .s_axil_rvalid  (s_rvalid),
        .s_axil_rready  (s_rready),
        .m_axil_araddr  (m_araddr),
        .m_axil_arprot  (m_arprot),
        .m_axil_arvalid (m_arvalid),
        .m_axil_arready (m_arready),
        .m_axil_rdata   (m_rdata),
        .m_axil_rresp   (m_rresp),
        .m_axil_rvalid  (m_rvalid),
        .m_axil_rready  (m_rready)
    );

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] data;
        logic [1:0]  resp;
    } txn_t;

    txn_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model knobs and state
    int          ar_stall = 0;
    int          r_delay  = 0;
    int          ar_cnt   = 0;
    int          r_cnt    = 0;
    bit          r_pending = 0;
    logic [1:0]  master_resp = 2'b00;
    logic [31:0] r_data_pend;
    logic [1:0]  r_resp_pend;
    int          rr_stall [S];

    // Snapshots from the previous sample point for hold checks
    bit          prev_m_ar_wait = 0;
    logic [31:0] prev_m_araddr;
    bit          prev_r_wait = 0;
    logic [S-1:0] prev_rvalid;
    logic [31:0] prev_rdata;
    logic [1:0]  prev_rresp;
    bit          prev_m_r_hs = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a == 32'h1000) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    task automatic issue(input int p, input logic [31:0] a);
        txn_t t;
        t.port = p;
        t.addr = a;
        t.prot = 3'(p + 1);
        t.data = mdata(a);
        t.resp = master_resp;
        exp_q.push_back(t);
        s_araddr[p*AW +: AW] = a;
        s_arprot[p*3 +: 3]   = t.prot;
        s_arvalid[p]         = 1'b1;
    endtask

    task automatic tick();
        logic [S-1:0] ar_hs;
        logic [S-1:0] r_hs;
        logic         m_ar_hs;
        logic         m_r_hs;
        logic [31:0]  cap_addr;
        txn_t         t;

        @(negedge clk);
        ar_hs    = s_arvalid & s_arready;
        r_hs     = s_rvalid & s_rready;
        m_ar_hs  = m_arvalid & m_arready;
        m_r_hs   = m_rvalid & m_rready;
        cap_addr = m_araddr;

        if (!rst) begin
            if (s_arready != '0) begin
                if (exp_q.size() == 0) check("arready_unexpected", s_arready, '0);
                else                   check("grant_port", s_arready, S'(1) << exp_q[0].port);
            end
            if (s_rvalid != '0 && exp_q.size() != 0)
                check("rvalid_port", s_rvalid, S'(1) << exp_q[0].port);
            if (prev_m_ar_wait)
                check("m_ar_hold", {m_arvalid, m_araddr}, {1'b1, prev_m_araddr});
            if (prev_r_wait)
                check("s_r_hold", {s_rvalid, s_rdata[31:0], s_rresp[1:0]},
                      {prev_rvalid, prev_rdata, prev_rresp});
            if (prev_m_r_hs && exp_q.size() != 0)
                check("r_latency", s_rvalid, S'(1) << exp_q[0].port);
            if (m_ar_hs) begin
                if (exp_q.size() == 0) begin
                    check("m_ar_unexpected", m_ar_hs, 1'b0);
                end else begin
                    check("m_araddr", m_araddr, exp_q[0].addr);
                    check("m_arprot", m_arprot, exp_q[0].prot);
                end
            end
            if (r_hs != '0) begin
                if (exp_q.size() == 0) begin
                    check("r_unexpected", r_hs, '0);
                end else begin
                    t = exp_q.pop_front();
                    check("r_port", r_hs, S'(1) << t.port);
                    check("rdata", s_rdata[t.port*DW +: DW], t.data);
                    check("rresp", s_rresp[t.port*2 +: 2], t.resp);
                    $display("txn port=%0d addr=%08h rdata=%08h rresp=%0d",
                             t.port, t.addr, s_rdata[t.port*DW +: DW], s_rresp[t.port*2 +: 2]);
                end
            end
            prev_m_ar_wait = m_arvalid && !m_arready;
            prev_m_araddr  = m_araddr;
            prev_r_wait    = (s_rvalid & ~s_rready) != '0;
            prev_rvalid    = s_rvalid;
            prev_rdata     = s_rdata[31:0];
            prev_rresp     = s_rresp[1:0];
            prev_m_r_hs    = m_r_hs;
        end else begin
            prev_m_ar_wait = 0;
            prev_r_wait    = 0;
            prev_m_r_hs    = 0;
        end

        @(posedge clk);
        #1;
        for (int p = 0; p < S; p++) begin
            if (ar_hs[p]) s_arvalid[p] = 1'b0;
            s_rready[p] = (rr_stall[p] == 0);
            if (s_rvalid[p] && rr_stall[p] > 0) rr_stall[p]--;
        end
        if (rst) begin
            m_arready = 1'b0;
            m_rvalid  = 1'b0;
            r_pending = 0;
            ar_cnt    = 0;
        end else begin
            if (m_ar_hs) begin
                m_arready   = 1'b0;
                ar_cnt      = 0;
                r_pending   = 1;
                r_cnt       = r_delay;
                r_data_pend = mdata(cap_addr);
                r_resp_pend = master_resp;
            end else if (m_arvalid) begin
                if (ar_cnt >= ar_stall) m_arready = 1'b1;
                else                    ar_cnt++;
            end
            if (m_r_hs) begin
                m_rvalid = 1'b0;
            end else if (r_pending) begin
                if (r_cnt == 0) begin
                    m_rvalid  = 1'b1;
                    m_rdata   = r_data_pend;
                    m_rresp   = r_resp_pend;
                    r_pending = 0;
                end else begin
                    r_cnt--;
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || s_arvalid != '0) && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_complete"}, (exp_q.size() == 0) && (s_arvalid == '0), 1'b1);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        s_arvalid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        s_araddr  = '0;
        s_arprot  = '0;
        s_arvalid = '0;
        s_rready  = '1;
        m_arready = 1'b0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        m_rvalid  = 1'b0;
        for (int p = 0; p < S; p++) rr_stall[p] = 0;

        repeat (3) tick();
        check("rst_s_arready", s_arready, '0);
        check("rst_s_rvalid", s_rvalid, '0);
        check("rst_m_arvalid", m_arvalid, 1'b0);
        check("rst_m_rready", m_rready, 1'b0);
        rst = 1'b0;

        // single read from port 2, with first-transaction latency
        issue(2, 32'h1000);
        tick();
        check("t1_arready_lat", s_arready, 4'b0100);
        check("t1_m_arvalid_early", m_arvalid, 1'b0);
        tick();
        check("t1_m_arvalid_lat", m_arvalid, 1'b1);
        check("t1_m_araddr", m_araddr, 32'h1000);
        drain("t1");

        // contention from reset: 0,1,2,3 then port 0 again after 3
        reset_dut();
        for (int p = 0; p < S; p++) issue(p, 32'h2000 + 32'(p * 16));
        n = 0;
        while (exp_q.size() > 3 && n < 100) begin
            tick();
            n++;
        end
        check("t2_first_done", exp_q.size(), 3);
        issue(0, 32'h2100);
        drain("t2");

        // fairness: port 3 overtakes a re-requesting port 0
        issue(0, 32'h3000);
        tick();
        issue(3, 32'h3030);
        n = 0;
        while (s_arvalid[0] && n < 50) begin
            tick();
            n++;
        end
        check("t3_p0_accepted", s_arvalid[0], 1'b0);
        issue(0, 32'h3004);
        drain("t3");

        // backpressure on every channel, second requester must wait
        ar_stall    = 7;
        r_delay     = 5;
        rr_stall[1] = 4;
        issue(1, 32'h4000);
        tick();
        tick();
        issue(0, 32'h4010);
        drain("t4");
        ar_stall = 0;
        r_delay  = 0;

        // error responses passed through untouched
        master_resp = 2'b10;
        issue(2, 32'h5000);
        drain("t5_slverr");
        master_resp = 2'b11;
        issue(3, 32'h5004);
        drain("t5_decerr");
        master_resp = 2'b00;

        // reset while waiting for master data
        r_delay = 10;
        issue(3, 32'h6000);
        n = 0;
        while (!m_rready && n < 50) begin
            tick();
            n++;
        end
        check("t6_in_data", m_rready, 1'b1);
        rst = 1'b1;
        tick();
        check("t6_s_arready", s_arready, '0);
        check("t6_s_rvalid", s_rvalid, '0);
        check("t6_m_arvalid", m_arvalid, 1'b0);
        check("t6_m_rready", m_rready, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        s_arvalid = '0;
        r_delay   = 0;
        issue(1, 32'h7000);
        drain("t6_after");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
